// File: rtl/memhot_out_monitor.sv
// Qualifies MEMHOT_OUT# from both CPU sockets: synchronize, glitch filter, minimum-assertion stretch,
// then report live/sticky status, saturating event counts and a shared BMC alert.
module memhot_out_monitor #(
    parameter int FILTER_CYCLES  = 4,
    parameter int STRETCH_CYCLES = 2000,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 PWRGD_SYS_PWROK,
    input  logic                 FM_CPU0_MEMHOT_OUT_N,
    input  logic                 FM_CPU1_MEMHOT_OUT_N,
    input  logic                 FM_CPU0_SKTOCC_LVT3_N,
    input  logic                 FM_CPU1_SKTOCC_LVT3_N,
    input  logic                 iStatusClr,
    output logic [1:0]           oMemhotActive,
    output logic [1:0]           oMemhotSticky,
    output logic [CNT_WIDTH-1:0] oCpu0EventCnt,
    output logic [CNT_WIDTH-1:0] oCpu1EventCnt,
    output logic                 FM_BMC_MEMHOT_ALERT_N
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUALIFY = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_STRETCH = 2'd3;

    localparam logic [7:0]           FILT_LAST = 8'(FILTER_CYCLES - 1);
    localparam logic [15:0]          STR_LAST  = 16'(STRETCH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]           state_q [2];
    logic [1:0]           state_d [2];
    logic [7:0]           filt_q  [2];
    logic [7:0]           filt_d  [2];
    logic [15:0]          str_q   [2];
    logic [15:0]          str_d   [2];
    logic [CNT_WIDTH-1:0] cnt_q   [2];
    logic [CNT_WIDTH-1:0] cnt_d   [2];
    logic [1:0]           active_q, active_d, sticky_q, sticky_d;
    logic [1:0]           en, evt;
    logic                 alert_q, alert_d;

    always_comb begin
        sync1_d = {FM_CPU1_MEMHOT_OUT_N, FM_CPU0_MEMHOT_OUT_N};
        sync2_d = sync1_q;
        en      = {PWRGD_SYS_PWROK & ~FM_CPU1_SKTOCC_LVT3_N,
                   PWRGD_SYS_PWROK & ~FM_CPU0_SKTOCC_LVT3_N};
    end

    // Per-socket qualify/stretch FSM; a low sample during stretch re-enters ACTIVE without a new event.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            state_d[n] = state_q[n];
            filt_d[n]  = filt_q[n];
            str_d[n]   = str_q[n];
            evt[n]     = 1'b0;
            if (!en[n]) begin
                state_d[n] = ST_IDLE;
                filt_d[n]  = 8'd0;
                str_d[n]   = 16'd0;
            end else begin
                case (state_q[n])
                    ST_IDLE: begin
                        if (!sync2_q[n]) begin
                            if (FILTER_CYCLES == 1) begin
                                state_d[n] = ST_ACTIVE;
                                evt[n]     = 1'b1;
                            end else begin
                                state_d[n] = ST_QUALIFY;
                                filt_d[n]  = 8'd1;
                            end
                        end else begin
                            filt_d[n] = 8'd0;
                        end
                    end
                    ST_QUALIFY: begin
                        if (sync2_q[n]) begin
                            state_d[n] = ST_IDLE;
                            filt_d[n]  = 8'd0;
                        end else if (filt_q[n] == FILT_LAST) begin
                            state_d[n] = ST_ACTIVE;
                            filt_d[n]  = 8'd0;
                            evt[n]     = 1'b1;
                        end else begin
                            filt_d[n] = filt_q[n] + 8'd1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (sync2_q[n]) begin
                            if (STRETCH_CYCLES == 1) begin
                                state_d[n] = ST_IDLE;
                            end else begin
                                state_d[n] = ST_STRETCH;
                                str_d[n]   = 16'd1;
                            end
                        end else begin
                            state_d[n] = ST_ACTIVE;
                        end
                    end
                    ST_STRETCH: begin
                        if (!sync2_q[n]) begin
                            state_d[n] = ST_ACTIVE;
                            str_d[n]   = 16'd0;
                        end else if (str_q[n] == STR_LAST) begin
                            state_d[n] = ST_IDLE;
                            str_d[n]   = 16'd0;
                        end else begin
                            str_d[n] = str_q[n] + 16'd1;
                        end
                    end
                    default: begin
                        state_d[n] = ST_IDLE;
                        filt_d[n]  = 8'd0;
                        str_d[n]   = 16'd0;
                    end
                endcase
            end
            active_d[n] = (state_d[n] == ST_ACTIVE) || (state_d[n] == ST_STRETCH);
        end
    end

    // Sticky bits and counters: an event on the same edge as a clear still registers.
    always_comb begin
        sticky_d = iStatusClr ? 2'b00 : sticky_q;
        for (int n = 0; n < 2; n++) begin
            cnt_d[n] = iStatusClr ? {CNT_WIDTH{1'b0}} : cnt_q[n];
            if (evt[n]) begin
                sticky_d[n] = 1'b1;
                if (iStatusClr) begin
                    cnt_d[n] = CNT_ONE;
                end else if (cnt_q[n] == CNT_MAX) begin
                    cnt_d[n] = cnt_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_ONE;
                end
            end else begin
                sticky_d[n] = sticky_d[n];
            end
        end
        alert_d = ~(sticky_q[0] | sticky_q[1]);
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            sync1_q  <= 2'b11;
            sync2_q  <= 2'b11;
            active_q <= 2'b00;
            sticky_q <= 2'b00;
            alert_q  <= 1'b1;
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= ST_IDLE;
                filt_q[n]  <= 8'd0;
                str_q[n]   <= 16'd0;
                cnt_q[n]   <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            active_q <= active_d;
            sticky_q <= sticky_d;
            alert_q  <= alert_d;
            for (int n = 0; n < 2; n++) begin
                state_q[n] <= state_d[n];
                filt_q[n]  <= filt_d[n];
                str_q[n]   <= str_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
        end
    end

    assign oMemhotActive         = active_q;
    assign oMemhotSticky         = sticky_q;
    assign oCpu0EventCnt         = cnt_q[0];
    assign oCpu1EventCnt         = cnt_q[1];
    assign FM_BMC_MEMHOT_ALERT_N = alert_q;

endmodule

// File: doc/memhot_out_monitor.md
Name: memhot_out_monitor

Overview:
- Receives MEMHOT_OUT# from each CPU memory controller and qualifies it. This is the throttle indication travelling back from the CPU, the opposite direction to MEMHOT_IN#.
- Per socket it applies a 2-flop synchronizer, a glitch filter and a minimum-assertion stretch. It then reports a live status, a sticky status and a saturating event count.
- A shared active-low alert goes to the BMC so management firmware can log a SEL event.
- Sits in the core CPLD beside the MEMHOT_IN# generator and is clocked by the same 2 MHz system clock.

Parameters:
- FILTER_CYCLES, 4: consecutive synchronized-low samples required to accept an event (range 1..255).
- STRETCH_CYCLES, 2000: minimum hold of the active status after the input releases (1 ms at 2 MHz, range 1..65535).
- CNT_WIDTH, 8: width of each per-socket event counter.

Ports:
- iClk  input  1  2 MHz system clock.
- iRst_n  input  1  synchronous active-low reset.
- PWRGD_SYS_PWROK  input  1  system power good; monitoring is enabled only when high.
- FM_CPU0_MEMHOT_OUT_N  input  1  CPU0 MEMHOT_OUT#, asynchronous, active low.
- FM_CPU1_MEMHOT_OUT_N  input  1  CPU1 MEMHOT_OUT#, asynchronous, active low.
- FM_CPU0_SKTOCC_LVT3_N  input  1  CPU0 socket occupied, active low.
- FM_CPU1_SKTOCC_LVT3_N  input  1  CPU1 socket occupied, active low.
- iStatusClr  input  1  single-cycle pulse; clears sticky bits and counters.
- oMemhotActive  output  2  bit n = socket n qualified MEMHOT, including stretch.
- oMemhotSticky  output  2  bit n = socket n has had a qualified event since the last clear.
- oCpu0EventCnt  output  CNT_WIDTH  CPU0 qualified event count, saturating.
- oCpu1EventCnt  output  CNT_WIDTH  CPU1 qualified event count, saturating.
- FM_BMC_MEMHOT_ALERT_N  output  1  low while any sticky bit is set.

Behaviour:
- One clock and one reset: iClk, with iRst_n synchronous and active low. All logic is updated on the iClk rising edge.
- Reset values:
  - oMemhotActive = 0, oMemhotSticky = 0, both counters = 0.
  - FM_BMC_MEMHOT_ALERT_N = 1.
  - Synchronizer flops = 1; FSMs in IDLE; filter and stretch counters = 0.
- Synchronizer: two flops per input. Their output s_n feeds the FSM.
- Enable: en_n = PWRGD_SYS_PWROK && !SKTOCCn_N.
  - When en_n = 0, FSM n is forced to IDLE on the next edge and oMemhotActive[n] = 0.
  - No events are counted while disabled.
  - Sticky bits and counters are retained while disabled.
- Per-socket FSM:
  - IDLE: s low -> QUALIFY, filter count = 1. Exception: if FILTER_CYCLES = 1, go directly to ACTIVE and record an event.
  - QUALIFY: s high -> IDLE. s low -> increment the filter count. On the edge where the FILTER_CYCLES-th consecutive low sample is seen -> ACTIVE and record an event.
  - ACTIVE: s low -> stay. s high -> STRETCH, stretch count = 1.
  - STRETCH: s low -> ACTIVE, with no new event (re-assertion during stretch is the same event). s high -> increment the stretch count. When the count reaches STRETCH_CYCLES -> IDLE.
- oMemhotActive[n] is registered and equals 1 in ACTIVE or STRETCH.
- Latency: if edge N is the first edge sampling the pin low, oMemhotActive rises after edge N+1+FILTER_CYCLES.
- Release: if the pin releases before edge E, oMemhotActive falls after edge E+1+STRETCH_CYCLES.
- Record event:
  - Sets oMemhotSticky[n].
  - Increments counter n; the counter saturates at 2^CNT_WIDTH-1 and never wraps.
- Clear:
  - iStatusClr zeroes both sticky bits and both counters on the next edge.
  - If a clear and an event for socket n occur on the same edge, the event wins: sticky[n] = 1 and counter n = 1.
  - A clear does not affect oMemhotActive or the FSMs.
- FM_BMC_MEMHOT_ALERT_N is registered and equals ~(sticky[0] | sticky[1]). It therefore lags the sticky bits by one cycle.
- Sockets are fully independent; simultaneous events on both sockets are both recorded.
- Reset asserted mid-event returns everything to reset values on that edge. After reset, a pin still held low is re-qualified from IDLE and counted as a new event.

Test Plan:
Bench parameters: FILTER_CYCLES = 4, STRETCH_CYCLES = 20, CNT_WIDTH = 8; PWROK = 1; both sockets occupied.
- Glitch: CPU0 pin low for 3 cycles -> oMemhotActive = 00, sticky = 00, counter 0 stays 0, alert stays 1.
- Qualified event:
  - Stimulus: CPU0 pin low for 10 cycles starting at edge N.
  - Required: active[0] rises after edge N+5, counter 0 = 1, sticky[0] = 1, alert goes low one cycle later.
  - Required: after the pin releases, active[0] stays high for 20 more cycles, then falls.
- Stretch merge: CPU1 pin low 10 cycles, high 8 cycles, low 10 cycles -> active[1] continuous, counter 1 = 1. Repeat with a 25-cycle gap -> counter 1 = 2.
- Saturation and clear:
  - 260 qualified CPU0 events -> counter 0 = 255.
  - iStatusClr pulse -> counter 0 = 0, sticky = 00, alert returns to 1.
  - Clear on the same edge as a new qualification -> counter = 1, sticky set.
- Gating:
  - CPU1 socket unoccupied (FM_CPU1_SKTOCC_LVT3_N = 1) with CPU1 pin low 50 cycles -> no CPU1 event.
  - PWROK drop during CPU0 ACTIVE -> active[0] = 0 next edge; sticky and counter retained.
- Reset mid-event: iRst_n low for 1 cycle while CPU0 is ACTIVE and the pin is held low -> all outputs return to reset values. After release, active[0] re-asserts after 5 cycles and counter 0 = 1.
